// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: drives instruction-memory reads, holds the
// instruction register and program counter, and strobes EXEC_EN once per
// retired instruction. A bounded fetch wait drops into a sticky fault state
// that START clears.
module fetch_sequencer #(
  parameter logic [4:0] PC_RST  = 5'd0,
  parameter int         TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        HALT_REQ,
  output logic        IM_REQ,
  output logic [4:0]  IM_ADDR,
  input  logic        IM_VALID,
  input  logic [15:0] IM_DATA,
  output logic [15:0] IR_OUT,
  input  logic        JMP,
  input  logic [4:0]  JMP_ADDR,
  output logic        EXEC_EN,
  output logic [4:0]  PC,
  output logic        BUSY,
  output logic        FAULT,
  output logic        WRAP,
  output logic [15:0] INSTR_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_FLT} state_t;

  localparam logic [15:0] IR_NOP  = 16'hA000;
  // Last miss count before giving up: the TIMEOUT-th empty FETCH cycle faults.
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic        halt_q, halt_d;
  logic        fault_q, fault_d;
  logic        wrap_q, wrap_d;

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    halt_d  = halt_q;
    fault_d = fault_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end
      end
      S_FETCH: begin
        if (HALT_REQ) halt_d = 1'b1;
        // Data arriving on the last allowed cycle wins over the timeout.
        if (IM_VALID) begin
          ir_d    = IM_DATA;
          state_d = S_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FLT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_EXEC: begin
        pc_d   = JMP ? JMP_ADDR : pc_q + 5'd1;
        // Only sequential roll-over counts as a wrap, not a jump to 0.
        wrap_d = !JMP && (pc_q == 5'd31);
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (halt_q || HALT_REQ) begin
          state_d = S_IDLE;
          halt_d  = 1'b0;
        end else begin
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end
      end
      S_FLT: begin
        if (START) begin
          state_d = S_FETCH;
          fault_d = 1'b0;
          wait_d  = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset abandoning any operation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      ir_q    <= IR_NOP;
      cnt_q   <= 16'd0;
      wait_q  <= 8'd0;
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      halt_q  <= halt_d;
      fault_q <= fault_d;
      wrap_q  <= wrap_d;
    end
  end

  // Control outputs decode registered state only.
  assign IM_REQ    = (state_q == S_FETCH);
  assign EXEC_EN   = (state_q == S_EXEC);
  assign BUSY      = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign IM_ADDR   = pc_q;
  assign PC        = pc_q;
  assign IR_OUT    = ir_q;
  assign FAULT     = fault_q;
  assign WRAP      = wrap_q;
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. A memory responder answers IM_REQ after
// a programmable latency; a monitor checks every EXEC_EN strobe against a
// scoreboard of expected {IR, PC, count} records queued with the stimulus.
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, HALT_REQ;
  logic        IM_REQ, IM_VALID, JMP, EXEC_EN, BUSY, FAULT, WRAP;
  logic [4:0]  IM_ADDR, JMP_ADDR, PC;
  logic [15:0] IM_DATA, IR_OUT, INSTR_CNT;

  typedef struct {
    logic [15:0] ir;
    logic [4:0]  pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [32];
  int          mem_lat = 0;
  int          req_cyc = 0;

  fetch_sequencer #(.PC_RST(5'd0), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .HALT_REQ(HALT_REQ),
    .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_VALID(IM_VALID), .IM_DATA(IM_DATA),
    .IR_OUT(IR_OUT), .JMP(JMP), .JMP_ADDR(JMP_ADDR), .EXEC_EN(EXEC_EN),
    .PC(PC), .BUSY(BUSY), .FAULT(FAULT), .WRAP(WRAP), .INSTR_CNT(INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  // Decoder stand-in: opcode F is a jump; F0A8 targets 21, others the low bits.
  function automatic logic [4:0] dec_target(input logic [15:0] ir);
    return (ir == 16'hF0A8) ? 5'd21 : ir[4:0];
  endfunction
  assign JMP      = (IR_OUT[15:12] == 4'hF);
  assign JMP_ADDR = dec_target(IR_OUT);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic push(input logic [15:0] ir, input logic [4:0] pc, input logic [15:0] cnt);
    exp_t e;
    e.ir = ir; e.pc = pc; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Memory responder: IM_VALID after mem_lat empty FETCH cycles.
  always @(negedge CLK) begin
    if (IM_REQ) begin
      if (req_cyc == mem_lat) begin
        IM_VALID = 1'b1;
        IM_DATA  = mem[IM_ADDR];
      end else begin
        IM_VALID = 1'b0;
      end
      req_cyc++;
    end else begin
      IM_VALID = 1'b0;
      req_cyc  = 0;
    end
  end

  // Monitor: every EXEC_EN strobe retires the oldest expected instruction.
  always @(negedge CLK) begin
    if (!RST && EXEC_EN) begin
      if (sb.size() == 0) begin
        chk("unexpected_exec", 32'(IR_OUT), 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("exec_ir", 32'(IR_OUT), 32'(e.ir));
        chk("exec_pc", 32'(PC), 32'(e.pc));
        chk("exec_cnt", 32'(INSTR_CNT), 32'(e.cnt));
      end
    end
  end

  initial begin
    IM_VALID = 1'b0; IM_DATA = 16'h0;
    foreach (mem[i]) mem[i] = 16'h0;
    RST = 1'b1; START = 1'b0; HALT_REQ = 1'b0;
    tick(); tick();
    chk("rst_im_req", 32'(IM_REQ), 0);
    chk("rst_exec_en", 32'(EXEC_EN), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_fault", 32'(FAULT), 0);
    chk("rst_wrap", 32'(WRAP), 0);
    chk("rst_pc", 32'(PC), 0);
    chk("rst_ir", 32'(IR_OUT), 32'hA000);
    chk("rst_cnt", 32'(INSTR_CNT), 0);
    RST = 1'b0;
    tick();

    // Basic run: single ADD, memory answers in the first FETCH cycle.
    mem[0] = 16'h0105;
    push(16'h0105, 5'd0, 16'd0);
    START = 1'b1; tick();
    START = 1'b0;
    chk("basic_im_req", 32'(IM_REQ), 1);
    chk("basic_im_addr", 32'(IM_ADDR), 0);
    HALT_REQ = 1'b1; tick();
    HALT_REQ = 1'b0; tick();
    chk("basic_exec_once", 32'(EXEC_EN), 0);
    chk("basic_im_addr_next", 32'(IM_ADDR), 1);
    chk("basic_cnt", 32'(INSTR_CNT), 1);
    chk("basic_busy", 32'(BUSY), 0);

    // Jump to 21, jump to 31, then sequential wrap to 0.
    mem[1] = 16'hF0A8; mem[21] = 16'hF01F; mem[31] = 16'h0203;
    push(16'hF0A8, 5'd1, 16'd1);
    push(16'hF01F, 5'd21, 16'd2);
    push(16'h0203, 5'd31, 16'd3);
    START = 1'b1; tick();
    START = 1'b0;
    chk("jmp_first_addr", 32'(IM_ADDR), 1);
    tick(); tick();
    chk("jmp_im_req", 32'(IM_REQ), 1);
    chk("jmp_im_addr", 32'(IM_ADDR), 21);
    chk("jmp_wrap", 32'(WRAP), 0);
    tick(); tick();
    chk("jmp31_addr", 32'(IM_ADDR), 31);
    HALT_REQ = 1'b1; tick();
    HALT_REQ = 1'b0; tick();
    chk("wrap_pulse", 32'(WRAP), 1);
    chk("wrap_pc", 32'(PC), 0);
    chk("wrap_busy", 32'(BUSY), 0);
    chk("wrap_cnt", 32'(INSTR_CNT), 4);
    tick();
    chk("wrap_one_cycle", 32'(WRAP), 0);

    // Jump from 31 to 0 must not pulse WRAP.
    mem[0] = 16'hF01F; mem[31] = 16'hF000;
    push(16'hF01F, 5'd0, 16'd4);
    push(16'hF000, 5'd31, 16'd5);
    START = 1'b1; tick();
    START = 1'b0; tick(); tick();
    HALT_REQ = 1'b1; tick();
    HALT_REQ = 1'b0; tick();
    chk("jmp0_wrap", 32'(WRAP), 0);
    chk("jmp0_pc", 32'(PC), 0);
    chk("jmp0_cnt", 32'(INSTR_CNT), 6);

    // Timeout: memory never answers; 8 FETCH cycles then fault.
    mem_lat = 255;
    START = 1'b1; tick();
    START = 1'b0;
    repeat (7) tick();
    chk("to_last_fetch_req", 32'(IM_REQ), 1);
    chk("to_last_fetch_fault", 32'(FAULT), 0);
    tick();
    chk("to_fault", 32'(FAULT), 1);
    chk("to_im_req", 32'(IM_REQ), 0);
    chk("to_busy", 32'(BUSY), 0);
    chk("to_pc", 32'(PC), 0);
    HALT_REQ = 1'b1; tick();
    HALT_REQ = 1'b0;
    chk("to_fault_sticky", 32'(FAULT), 1);
    mem_lat = 0; mem[0] = 16'h0105;
    push(16'h0105, 5'd0, 16'd6);
    START = 1'b1; tick();
    START = 1'b0;
    chk("to_restart_req", 32'(IM_REQ), 1);
    chk("to_restart_addr", 32'(IM_ADDR), 0);
    chk("to_restart_fault", 32'(FAULT), 0);
    HALT_REQ = 1'b1; tick();
    HALT_REQ = 1'b0; tick();
    chk("to_after_pc", 32'(PC), 1);
    chk("to_after_cnt", 32'(INSTR_CNT), 7);

    // Halt pulsed during a slow fetch; fetch still completes.
    mem[1] = 16'h0105; mem_lat = 3;
    push(16'h0105, 5'd1, 16'd7);
    START = 1'b1; tick();
    START = 1'b0; HALT_REQ = 1'b1; tick();
    HALT_REQ = 1'b0;
    chk("halt_still_fetch", 32'(IM_REQ), 1);
    tick(); tick();
    chk("halt_fetch_done_req", 32'(IM_REQ), 1);
    chk("halt_no_early_exec", 32'(EXEC_EN), 0);
    tick();
    START = 1'b1; tick();
    START = 1'b0;
    chk("halt_idle_busy", 32'(BUSY), 0);
    chk("halt_idle_exec", 32'(EXEC_EN), 0);
    chk("halt_pc", 32'(PC), 2);
    tick();
    chk("halt_start_ignored", 32'(BUSY), 0);

    // Data on the 8th FETCH cycle beats the timeout.
    mem[2] = 16'h0301; mem_lat = 7;
    push(16'h0301, 5'd2, 16'd8);
    START = 1'b1; tick();
    START = 1'b0; HALT_REQ = 1'b1; tick();
    HALT_REQ = 1'b0;
    repeat (6) tick();
    chk("edge_req", 32'(IM_REQ), 1);
    tick(); tick();
    chk("edge_no_fault", 32'(FAULT), 0);
    chk("edge_pc", 32'(PC), 3);
    chk("edge_cnt", 32'(INSTR_CNT), 9);

    // Reset mid-EXEC from a freshly reset block.
    mem_lat = 0;
    RST = 1'b1; tick();
    RST = 1'b0;
    chk("rst2_pc", 32'(PC), 0);
    chk("rst2_cnt", 32'(INSTR_CNT), 0);
    mem[0] = 16'h0105;
    push(16'h0105, 5'd0, 16'd0);
    START = 1'b1; tick();
    START = 1'b0; tick();
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_exec_en", 32'(EXEC_EN), 0);
    chk("mid_rst_busy", 32'(BUSY), 0);
    chk("mid_rst_pc", 32'(PC), 0);
    chk("mid_rst_cnt", 32'(INSTR_CNT), 0);
    chk("mid_rst_ir", 32'(IR_OUT), 32'hA000);
    tick();
    RST = 1'b0; tick();
    chk("post_rst_pc", 32'(PC), 0);
    chk("post_rst_cnt", 32'(INSTR_CNT), 0);
    push(16'h0105, 5'd0, 16'd0);
    START = 1'b1; tick();
    START = 1'b0;
    chk("refetch_req", 32'(IM_REQ), 1);
    chk("refetch_addr", 32'(IM_ADDR), 0);
    HALT_REQ = 1'b1; tick();
    HALT_REQ = 1'b0; tick();
    chk("refetch_pc", 32'(PC), 1);
    chk("refetch_cnt", 32'(INSTR_CNT), 1);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter PC_RST, default 5'd0, meaning the PC value loaded at reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 8, meaning the maximum number of FETCH cycles to wait for IM_VALID (legal range 1..255).
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port START  input  1  begins execution from IDLE, or clears a fault from FAULT.
REQ-006 The block SHALL have port HALT_REQ  input  1  requests a stop after the current instruction.
REQ-007 The block SHALL have port IM_REQ  output  1  instruction-memory read request, level.
REQ-008 The block SHALL have port IM_ADDR  output  5  instruction-memory address, equal to PC.
REQ-009 The block SHALL have port IM_VALID  input  1  instruction-memory data valid.
REQ-010 The block SHALL have port IM_DATA  input  16  instruction word.
REQ-011 The block SHALL have port IR_OUT  output  16  instruction register, driving the decoder ID_IN.
REQ-012 The block SHALL have port JMP  input  1  decoder jump flag, combinational from IR_OUT.
REQ-013 The block SHALL have port JMP_ADDR  input  5  decoder jump target.
REQ-014 The block SHALL have port EXEC_EN  output  1  one-cycle strobe qualifying decoder RF_EN, DM_EN and ACC_EN.
REQ-015 The block SHALL have port PC  output  5  program counter.
REQ-016 The block SHALL have port BUSY  output  1  high in FETCH and EXEC.
REQ-017 The block SHALL have port FAULT  output  1  sticky fetch-timeout flag.
REQ-018 The block SHALL have port WRAP  output  1  one-cycle pulse when PC wraps from 31 to 0.
REQ-019 The block SHALL have port INSTR_CNT  output  16  retired-instruction count, saturating at 16'hFFFF.

Function
REQ-020 The block SHALL implement states IDLE, FETCH, EXEC and FLT.
- IDLE: START=1 moves to FETCH on the next edge; otherwise stays in IDLE.
REQ-021 FETCH SHALL behave as follows:
- IM_REQ=1 and IM_ADDR=PC, held until IM_VALID=1.
- On IM_VALID=1: IR_OUT <= IM_DATA, then move to EXEC.
REQ-022 A FETCH wait counter SHALL clear on entering FETCH and increment on each FETCH cycle with IM_VALID=0.
- When it reaches TIMEOUT, the next state is FLT and FAULT <= 1.
- IM_VALID in the same cycle the count reaches TIMEOUT takes priority: no fault.
REQ-023 EXEC SHALL last exactly one cycle, during which EXEC_EN=1 and IR_OUT is stable.
- At the end edge: PC <= JMP ? JMP_ADDR : PC+1, mod 32.
- At the end edge: INSTR_CNT increments, saturating.
REQ-024 WRAP SHALL be 1 in the cycle after an EXEC where PC=31, JMP=0 and PC becomes 0; a jump to 0 SHALL NOT pulse WRAP.
REQ-025 HALT_REQ SHALL be latched into a pending flag whenever it is seen in FETCH or EXEC.
- At the end of EXEC, if the flag is set or HALT_REQ=1, the next state is IDLE and the flag clears; otherwise the next state is FETCH.
- HALT_REQ in IDLE or FLT is ignored.
REQ-026 A fetch in progress SHALL always complete; a halt never aborts an outstanding IM_REQ.
REQ-027 FLT SHALL drive IM_REQ=0, EXEC_EN=0 and FAULT=1; START=1 clears FAULT and moves to FETCH at the unchanged PC.
REQ-028 START while BUSY=1 SHALL be ignored.
REQ-029 Throughput SHALL be one instruction per 2 cycles minimum, reached when IM_VALID is high in the first FETCH cycle.
REQ-030 EXEC_EN, IM_REQ and BUSY SHALL be decoded from registered state only.

Reset
REQ-031 On RST=1, the block SHALL asynchronously reset:
- state IDLE, PC=PC_RST, IR_OUT=16'hA000 (NOP), INSTR_CNT=0.
- FAULT=0, WRAP=0, IM_REQ=0, EXEC_EN=0, BUSY=0.
- wait counter and halt-pending flag cleared.
REQ-032 RST asserted mid-fetch or mid-EXEC SHALL abandon the operation with no PC or counter update; the next START refetches from PC_RST.

Verification
REQ-033 The bench SHALL cover basic run:
- PC_RST=0, START pulse, IM_VALID same cycle as IM_REQ, IM_DATA=16'h0105 (ADD).
- Required: EXEC_EN one cycle, then IM_ADDR=1, INSTR_CNT=1.
REQ-034 The bench SHALL cover jump:
- IR=16'hF0A8 with JMP=1, JMP_ADDR=21.
- Required: next IM_ADDR=21, WRAP=0.
REQ-035 The bench SHALL cover wrap:
- PC=31, non-jump instruction.
- Required: PC=0, WRAP pulses one cycle.
REQ-036 The bench SHALL cover timeout:
- TIMEOUT=8, IM_VALID held low.
- Required: FAULT=1 after 8 FETCH cycles, IM_REQ=0, PC unchanged.
- Then START: IM_REQ=1 at the same PC.
REQ-037 The bench SHALL cover halt with slow memory:
- HALT_REQ pulsed during FETCH, IM_VALID 3 cycles late.
- Required: fetch completes, EXEC_EN once, then IDLE with BUSY=0.
REQ-038 The bench SHALL cover reset mid-EXEC:
- RST asserted during EXEC.
- Required: immediate IDLE, PC=PC_RST, EXEC_EN=0, INSTR_CNT unchanged from the pre-reset value of 0.
